// File: rtl/pet_pkg.sv
// pet_pkg: shared definitions for the pet statistics engine.
//   - ASCII command codes delivered by the UART/button decoder
//   - stat index assignments
//   - AWAKE/SLEEPING state encoding
package pet_pkg;

    localparam logic [7:0] CMD_IDLE  = 8'h00;
    localparam logic [7:0] CMD_EAT   = 8'h65;  // 'e'
    localparam logic [7:0] CMD_PLAY  = 8'h70;  // 'p'
    localparam logic [7:0] CMD_BATH  = 8'h62;  // 'b'
    localparam logic [7:0] CMD_SLEEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_TALK  = 8'h74;  // 't'
    localparam logic [7:0] CMD_WAKE  = 8'h77;  // 'w'

    localparam int IDX_HUNGER  = 0;
    localparam int IDX_HAPPY   = 1;
    localparam int IDX_HYGIENE = 2;
    localparam int IDX_ENERGY  = 3;
    localparam int IDX_SOCIAL  = 4;

    typedef enum logic {
        AWAKE    = 1'b0,
        SLEEPING = 1'b1
    } state_t;

endpackage

// File: rtl/pet_stats_engine_stat_counter.sv
// stat_counter: one saturating need counter.
// Ports:
//   clk, reset  clock, async active-high reset (clears value)
//   inc, dec    step requests for this cycle; both together cancel out
//   value       current counter value, held in [0, STAT_MAX]
//   at_max      value == STAT_MAX
module stat_counter #(
    parameter int STAT_W   = 5,
    parameter int STAT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [STAT_W-1:0] value,
    output logic              at_max
);

    localparam logic [STAT_W-1:0] MAX_V = STAT_W'(STAT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (inc && !dec && value < MAX_V) begin
            value <= value + STAT_W'(1);
        end else if (dec && !inc && value != '0) begin
            value <= value - STAT_W'(1);
        end
    end

    assign at_max = (value == MAX_V);

endmodule

// File: rtl/pet_stats_engine.sv
// pet_stats_engine: NUM_STATS saturating need counters for the pet.
// Counters rise at random on each tick, fall on accepted care commands, and the
// energy counter drains every second tick while the pet sleeps.
// Ports:
//   clk, reset     system clock, async active-high reset
//   cmd            ASCII command, 8'h00 = idle / key released
//   random         LFSR value, low SEL_W bits pick the stat that decays this tick
//   stats          packed counters, stat i at [i*STAT_W +: STAT_W]
//   tick           one-cycle pulse per tick period
//   second         toggles on every tick (animation phase)
//   is_sleeping    sleep FSM is in SLEEPING
//   critical       some stat is at STAT_MAX
//   critical_mask  per-stat at-max flags
//   cmd_ack        one-cycle pulse after a command is accepted
module pet_stats_engine
    import pet_pkg::*;
#(
    parameter int NUM_STATS  = 5,
    parameter int STAT_W     = 5,
    parameter int STAT_MAX   = 15,
    parameter int TICK_DIV   = 27000000,
    parameter int SEL_W      = 3,
    parameter int ENERGY_IDX = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  cmd,
    input  logic [7:0]                  random,
    output logic [NUM_STATS*STAT_W-1:0] stats,
    output logic                        tick,
    output logic                        second,
    output logic                        is_sleeping,
    output logic                        critical,
    output logic [NUM_STATS-1:0]        critical_mask,
    output logic                        cmd_ack
);

    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]     count;
    logic                 tick_now;
    logic [SEL_W-1:0]     sel;
    logic [NUM_STATS-1:0] inc;
    logic [NUM_STATS-1:0] dec;
    logic                 known_cmd;
    logic                 accept;
    logic                 drain;
    logic                 drained;
    logic                 armed;
    int                   cmd_idx;
    state_t               state;
    logic [STAT_W-1:0]    energy;
    logic                 unused_random;

    // Tick divider. Stat updates happen on the same edge that raises tick,
    // so the tick pulse is visible together with its effect on stats.
    assign tick_now = (count == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            tick   <= 1'b0;
            second <= 1'b0;
        end else begin
            count  <= tick_now ? '0 : count + CNT_W'(1);
            tick   <= tick_now;
            second <= second ^ tick_now;
        end
    end

    assign sel           = random[SEL_W-1:0];
    assign unused_random = ^random;
    assign energy        = stats[ENERGY_IDX*STAT_W +: STAT_W];

    // Drain uses second before its toggle: every other tick while asleep.
    assign drain = tick_now && (state == SLEEPING) && second;

    assign known_cmd = (cmd == CMD_EAT)  || (cmd == CMD_PLAY) || (cmd == CMD_BATH) ||
                       (cmd == CMD_TALK) || (cmd == CMD_SLEEP);
    assign accept    = armed && (state == AWAKE) && !critical && known_cmd;

    always_comb begin
        cmd_idx = -1;
        case (cmd)
            CMD_EAT:  cmd_idx = IDX_HUNGER;
            CMD_PLAY: cmd_idx = IDX_HAPPY;
            CMD_BATH: cmd_idx = IDX_HYGIENE;
            CMD_TALK: cmd_idx = IDX_SOCIAL;
            default:  cmd_idx = -1;
        endcase
        inc = '0;
        dec = '0;
        // Indices outside 0..NUM_STATS-1 simply match nothing.
        for (int i = 0; i < NUM_STATS; i++) begin
            inc[i] = tick_now && (int'(sel) == i);
            dec[i] = (accept && cmd_idx == i) || (drain && i == ENERGY_IDX);
        end
    end

    for (genvar g = 0; g < NUM_STATS; g++) begin : g_stat
        stat_counter #(
            .STAT_W   (STAT_W),
            .STAT_MAX (STAT_MAX)
        ) u_stat (
            .clk    (clk),
            .reset  (reset),
            .inc    (inc[g]),
            .dec    (dec[g]),
            .value  (stats[g*STAT_W +: STAT_W]),
            .at_max (critical_mask[g])
        );
    end

    assign critical = |critical_mask;

    // Arming: a key must be released (cmd==0) before the next accept, so a
    // held key acts once. drained remembers a drain so the wake check sees
    // the post-drain energy value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= AWAKE;
            armed   <= 1'b1;
            cmd_ack <= 1'b0;
            drained <= 1'b0;
        end else begin
            cmd_ack <= accept;
            drained <= drain;
            if (cmd == CMD_IDLE)
                armed <= 1'b1;
            else if (accept)
                armed <= 1'b0;
            case (state)
                AWAKE: begin
                    if (accept && cmd == CMD_SLEEP)
                        state <= SLEEPING;
                end
                SLEEPING: begin
                    if (cmd == CMD_WAKE || critical || (drained && energy == '0))
                        state <= AWAKE;
                end
                default: state <= AWAKE;
            endcase
        end
    end

    assign is_sleeping = (state == SLEEPING);

endmodule

// File: tb/tb_pet_stats_engine.sv
module tb_pet_stats_engine;
    import pet_pkg::*;

    localparam int N = 5;
    localparam int W = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [7:0]     cmd = 8'h00;
    logic [7:0]     random = 8'h00;
    logic [N*W-1:0] stats;
    logic           tick, second, is_sleeping, critical, cmd_ack;
    logic [N-1:0]   critical_mask;

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;
    int exp_q[$];

    pet_stats_engine #(
        .NUM_STATS(N), .STAT_W(W), .STAT_MAX(15), .TICK_DIV(4), .SEL_W(3), .ENERGY_IDX(3)
    ) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .random(random), .stats(stats),
        .tick(tick), .second(second), .is_sleeping(is_sleeping), .critical(critical),
        .critical_mask(critical_mask), .cmd_ack(cmd_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int stat(input int i);
        return int'(stats[i*W +: W]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (cmd_ack === 1'b1) ack_cnt++;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 10);
        if (tick !== 1'b1) begin
            checks++; errors++;
            $display("FAIL tick_timeout: tick=%b after %0d cycles, want 1", tick, n);
        end
    endtask

    task automatic do_reset();
        cmd = 8'h00; random = 8'h00;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        ack_cnt = 0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (stats !== '0) begin errors++; $display("FAIL %s stats: got %h want 0", tag, stats); end
        checks++;
        if ({tick, second, is_sleeping, cmd_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL %s tick/second/sleep/ack: got %b want 0000", tag, {tick, second, is_sleeping, cmd_ack});
        end
        checks++;
        if ({critical, critical_mask} !== 6'b0) begin
            errors++; $display("FAIL %s critical: got %b want 0", tag, {critical, critical_mask});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        check_reset_values("reset");
        reset = 1'b0;
        ack_cnt = 0;
    endtask

    task automatic test_tick();
        int k, e;
        logic et;
        k = 0;
        random = 8'd0;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        for (int i = 1; i <= 12; i++) begin
            step();
            et = (i % 4 == 0);
            checks++;
            if (tick !== et) begin errors++; $display("FAIL tick_cycle%0d: got %b want %b", i, tick, et); end
            if (tick === 1'b1) begin
                k++;
                e = exp_q.pop_front();
                checks++;
                if (stat(0) !== e) begin errors++; $display("FAIL tick_stat0 #%0d: got %0d want %0d", k, stat(0), e); end
                checks++;
                if (second !== k[0]) begin errors++; $display("FAIL tick_second #%0d: got %b want %b", k, second, k[0]); end
            end
        end
    endtask

    task automatic test_held_key();
        int e;
        random = 8'd7;
        ack_cnt = 0;
        exp_q.delete();
        exp_q.push_back(2); exp_q.push_back(1);
        for (int s = 1; s <= 10; s++) begin
            cmd = (s <= 6 || s == 8) ? CMD_EAT : CMD_IDLE;
            step();
            if (cmd_ack === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL held_key_extra_ack: cycle %0d got ack want none", s);
                end else begin
                    e = exp_q.pop_front();
                    if (stat(0) !== e) begin errors++; $display("FAIL held_key_stat0: got %0d want %0d", stat(0), e); end
                end
            end
        end
        cmd = CMD_IDLE;
        checks++;
        if (ack_cnt !== 2) begin errors++; $display("FAIL held_key_acks: got %0d want 2", ack_cnt); end
    endtask

    task automatic test_critical();
        int n, e;
        random = 8'd1;
        n = 0;
        while (stat(1) != 15 && n < 100) begin step(); n++; end
        checks++;
        if (stat(1) !== 15) begin errors++; $display("FAIL crit_reach: stat1=%0d want 15", stat(1)); end
        checks++;
        if (critical !== 1'b1) begin errors++; $display("FAIL crit_flag: got %b want 1", critical); end
        checks++;
        if (critical_mask !== 5'b00010) begin errors++; $display("FAIL crit_mask: got %b want 00010", critical_mask); end
        ack_cnt = 0;
        cmd = CMD_PLAY;
        step(); step(); step();
        cmd = CMD_IDLE;
        for (int t = 0; t < 2; t++) begin
            exp_q.push_back(15);
            wait_tick();
            e = exp_q.pop_front();
            checks++;
            if (stat(1) !== e) begin errors++; $display("FAIL crit_sat: stat1=%0d want %0d", stat(1), e); end
        end
        checks++;
        if (ack_cnt !== 0) begin errors++; $display("FAIL crit_ack: got %0d acks want 0", ack_cnt); end
    endtask

    task automatic test_sleep();
        int e;
        do_reset();
        random = 8'd3;
        repeat (4) wait_tick();
        checks++;
        if (stat(3) !== 4) begin errors++; $display("FAIL sleep_setup: energy=%0d want 4", stat(3)); end
        random = 8'd7;
        cmd = CMD_SLEEP;
        step();
        cmd = CMD_IDLE;
        checks++;
        if ({is_sleeping, cmd_ack} !== 2'b11) begin
            errors++; $display("FAIL sleep_enter: sleep/ack=%b want 11", {is_sleeping, cmd_ack});
        end
        exp_q.push_back(4); exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(2);
        for (int k = 0; k < 4; k++) begin
            wait_tick();
            e = exp_q.pop_front();
            checks++;
            if (stat(3) !== e) begin errors++; $display("FAIL sleep_drain tick%0d: energy=%0d want %0d", k, stat(3), e); end
            if (k == 1) begin
                cmd = CMD_EAT;
                step();
                cmd = CMD_IDLE;
                checks++;
                if (cmd_ack !== 1'b0 || stat(0) !== 0) begin
                    errors++; $display("FAIL sleep_ignore: ack=%b stat0=%0d want 0/0", cmd_ack, stat(0));
                end
            end
        end
        cmd = CMD_WAKE;
        step();
        cmd = CMD_IDLE;
        checks++;
        if (is_sleeping !== 1'b0) begin errors++; $display("FAIL sleep_wake: is_sleeping=%b want 0", is_sleeping); end
    endtask

    task automatic test_auto_wake();
        do_reset();
        random = 8'd3;
        wait_tick();
        random = 8'd7;
        cmd = CMD_SLEEP;
        step();
        cmd = CMD_IDLE;
        wait_tick();
        checks++;
        if (stat(3) !== 0 || is_sleeping !== 1'b1) begin
            errors++; $display("FAIL auto_wake_drain: energy=%0d sleep=%b want 0/1", stat(3), is_sleeping);
        end
        step();
        checks++;
        if (is_sleeping !== 1'b0) begin errors++; $display("FAIL auto_wake: is_sleeping=%b want 0", is_sleeping); end
        wait_tick(); wait_tick();
        checks++;
        if (stat(3) !== 0) begin errors++; $display("FAIL auto_wake_hold: energy=%0d want 0", stat(3)); end
    endtask

    task automatic test_collision();
        int e;
        do_reset();
        random = 8'd0;
        repeat (5) wait_tick();
        checks++;
        if (stat(0) !== 5) begin errors++; $display("FAIL coll_setup: stat0=%0d want 5", stat(0)); end
        step(); step(); step();
        cmd = CMD_EAT;
        exp_q.push_back(5);
        step();
        cmd = CMD_IDLE;
        e = exp_q.pop_front();
        checks++;
        if ({tick, cmd_ack} !== 2'b11 || stat(0) !== e) begin
            errors++; $display("FAIL collision: tick/ack=%b stat0=%0d want 11/%0d", {tick, cmd_ack}, stat(0), e);
        end
    endtask

    task automatic test_reset_mid_sleep();
        random = 8'd7;
        step();
        cmd = CMD_SLEEP;
        step();
        checks++;
        if (is_sleeping !== 1'b1) begin errors++; $display("FAIL mid_sleep_enter: is_sleeping=%b want 1", is_sleeping); end
        cmd = CMD_EAT;
        step();
        #2 reset = 1'b1;
        #1 check_reset_values("reset_async");
        step(); step();
        check_reset_values("reset_held");
        cmd = CMD_IDLE;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tick();
        test_held_key();
        test_critical();
        test_sleep();
        test_auto_wake();
        test_collision();
        test_reset_mid_sleep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
